// File: rtl/piton_endp_port.sv
// Endpoint side of a Piton router local port: TX buffer throttled by valid/yummy
// credits toward the router, and a show-ahead RX buffer that returns one yummy per pop.
module piton_endp_port #(
    parameter int DATA_W   = 64,
    parameter int CREDITS  = 4,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_W-1:0]                  tx_data_i,
    input  logic                               tx_valid_i,
    output logic                               tx_ready_o,
    output logic [DATA_W-1:0]                  dataOut,
    output logic                               validOut,
    input  logic                               yummyIn,
    input  logic [DATA_W-1:0]                  dataIn,
    input  logic                               validIn,
    output logic                               yummyOut,
    output logic [DATA_W-1:0]                  rx_data_o,
    output logic                               rx_valid_o,
    input  logic                               rx_ready_i,
    output logic [$clog2(CREDITS+1)-1:0]       credit_o,
    output logic [1:0]                         err_o
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int CW    = $clog2(CREDITS+1);

    localparam logic [TX_AW:0] TX_FULL    = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL    = (RX_AW+1)'(RX_DEPTH);
    localparam logic [CW-1:0]  CREDIT_MAX = CW'(CREDITS);

    // ---------------- TX path ----------------
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]  tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [TX_AW:0]    tx_count_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              valid_out_reg;
    logic [CW-1:0]     credit_reg, credit_next;
    logic              credit_ovf;
    logic              tx_push, tx_send;

    assign tx_ready_o = (tx_count_reg < TX_FULL);
    assign tx_push    = tx_valid_i && tx_ready_o;
    assign tx_send    = (tx_count_reg != '0) && (credit_reg != '0);

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr_reg] <= tx_data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            if (tx_push)
                tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_send) begin
                tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
                data_out_reg  <= tx_mem[tx_rd_ptr_reg];
            end
            case ({tx_push, tx_send})
                2'b10:   tx_count_reg <= tx_count_reg + 1'b1;
                2'b01:   tx_count_reg <= tx_count_reg - 1'b1;
                default: tx_count_reg <= tx_count_reg;
            endcase
            valid_out_reg <= tx_send;
        end
    end

    // A send and a returned credit in the same cycle cancel out.
    always_comb begin
        credit_next = credit_reg;
        credit_ovf  = 1'b0;
        if (tx_send && !yummyIn) begin
            credit_next = credit_reg - 1'b1;
        end else if (!tx_send && yummyIn) begin
            if (credit_reg == CREDIT_MAX)
                credit_ovf = 1'b1;
            else
                credit_next = credit_reg + 1'b1;
        end
    end

    // ---------------- RX path ----------------
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]  rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [RX_AW:0]    rx_count_reg;
    logic              yummy_out_reg;
    logic              rx_full, rx_pop, rx_push, rx_ovf;

    assign rx_full    = (rx_count_reg == RX_FULL);
    assign rx_valid_o = (rx_count_reg != '0);
    assign rx_pop     = rx_valid_o && rx_ready_i;
    // When full, a simultaneous pop frees the head slot, which is the one being written.
    assign rx_push    = validIn && (!rx_full || rx_pop);
    assign rx_ovf     = validIn && rx_full && !rx_pop;
    assign rx_data_o  = rx_valid_o ? rx_mem[rx_rd_ptr_reg] : '0;

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_ptr_reg] <= dataIn;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
            yummy_out_reg <= 1'b0;
        end else begin
            if (rx_push)
                rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)
                rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count_reg <= rx_count_reg + 1'b1;
                2'b01:   rx_count_reg <= rx_count_reg - 1'b1;
                default: rx_count_reg <= rx_count_reg;
            endcase
            yummy_out_reg <= rx_pop;
        end
    end

    // ---------------- credit and sticky error state ----------------
    logic [1:0] err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_reg <= CREDIT_MAX;
            err_reg    <= 2'b00;
        end else begin
            credit_reg <= credit_next;
            err_reg    <= err_reg | {rx_ovf, credit_ovf};
        end
    end

    assign dataOut  = data_out_reg;
    assign validOut = valid_out_reg;
    assign yummyOut = yummy_out_reg;
    assign credit_o = credit_reg;
    assign err_o    = err_reg;

endmodule

// File: tb/tb_piton_endp_port.sv
// Directed bench for piton_endp_port: inputs change and outputs are sampled on the
// falling edge, so every check sees the state left by the preceding rising edge.
module tb_piton_endp_port;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [63:0] dataOut;
    logic        validOut;
    logic        yummyIn;
    logic [63:0] dataIn;
    logic        validIn;
    logic        yummyOut;
    logic [63:0] rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic [2:0]  credit_o;
    logic [1:0]  err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piton_endp_port #(
        .DATA_W(64), .CREDITS(4), .TX_DEPTH(4), .RX_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .dataOut(dataOut), .validOut(validOut), .yummyIn(yummyIn),
        .dataIn(dataIn), .validIn(validIn), .yummyOut(yummyOut),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .credit_o(credit_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; tx_data_i = '0; tx_valid_i = 1'b0; yummyIn = 1'b0;
        dataIn = '0; validIn = 1'b0; rx_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Reset / idle state
        chk("idle_validOut", validOut, 0);
        chk("idle_yummyOut", yummyOut, 0);
        chk("idle_credit", credit_o, 4);
        chk("idle_tx_ready", tx_ready_o, 1);
        chk("idle_rx_valid", rx_valid_o, 0);
        chk("idle_rx_data", rx_data_o, 0);
        chk("idle_dataOut", dataOut, 0);
        chk("idle_err", err_o, 0);
        $display("txn reset/idle checked");

        // Push 0x1..0x6 with no credit return: 0x1..0x4 leave, 0x5/0x6 wait
        for (int k = 0; k < 8; k++) begin
            if (k >= 1) chk($sformatf("burst_valid_%0d", k), validOut, (k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) chk($sformatf("burst_data_%0d", k), dataOut, k - 1);
            tx_valid_i = (k < 6);
            tx_data_i  = k + 1;
            @(negedge clk);
        end
        chk("burst_credit0", credit_o, 0);
        chk("burst_tx_ready", tx_ready_o, 1);
        $display("txn burst 0x1..0x6 credit=%0d", credit_o);

        // One yummy releases 0x5 two cycles later
        yummyIn = 1'b1;
        @(negedge clk);
        yummyIn = 1'b0;
        chk("yummy1_credit", credit_o, 1);
        chk("yummy1_valid", validOut, 0);
        @(negedge clk);
        chk("send5_valid", validOut, 1);
        chk("send5_data", dataOut, 64'h5);
        chk("send5_credit", credit_o, 0);
        $display("txn single yummy released 0x%0h", dataOut);

        // Credit 1 with coincident send and yummy, then streaming
        yummyIn = 1'b1;
        @(negedge clk);
        chk("co_credit_pre", credit_o, 1);
        chk("co_valid_pre", validOut, 0);
        tx_valid_i = 1'b1; tx_data_i = 64'h7;
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("stream_valid_%0d", j), validOut, 1);
            chk($sformatf("stream_data_%0d", j), dataOut, 6 + j);
            chk($sformatf("stream_credit_%0d", j), credit_o, 1);
            tx_valid_i = (j < 3);
            tx_data_i  = 8 + j;
            yummyIn    = (j < 4);
            @(negedge clk);
        end
        chk("stream_end_valid", validOut, 0);
        chk("stream_end_credit", credit_o, 1);
        $display("txn streaming 0x6..0xa at credit 1");

        // Refill to 4, then overflow the credit counter
        yummyIn = 1'b1;
        repeat (3) @(negedge clk);
        chk("refill_credit", credit_o, 4);
        chk("refill_err", err_o, 0);
        @(negedge clk);
        yummyIn = 1'b0;
        chk("ovf_credit", credit_o, 4);
        chk("ovf_err", err_o, 2'b01);
        $display("txn credit overflow err=%b", err_o);

        // RX: fill 0xA0..0xA3 with no pop
        for (int j = 0; j < 4; j++) begin
            validIn = 1'b1; dataIn = 64'hA0 + j;
            @(negedge clk);
            chk($sformatf("rx_fill_valid_%0d", j), rx_valid_o, 1);
            chk($sformatf("rx_fill_head_%0d", j), rx_data_o, 64'hA0);
        end
        validIn = 1'b0;
        chk("rx_full_yummy", yummyOut, 0);
        // Overflow while full and not popping
        validIn = 1'b1; dataIn = 64'hEE;
        @(negedge clk);
        validIn = 1'b0;
        chk("rx_ovf_err", err_o, 2'b11);
        chk("rx_ovf_head", rx_data_o, 64'hA0);
        $display("txn rx overflow err=%b", err_o);

        // Drain in order with one yummy per pop
        rx_ready_i = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain_yummy_%0d", j), yummyOut, 1);
            if (j < 3) chk($sformatf("drain_head_%0d", j), rx_data_o, 64'hA1 + j);
            else       chk("drain_empty", rx_valid_o, 0);
            @(negedge clk);
        end
        rx_ready_i = 1'b0;
        chk("drain_yummy_end", yummyOut, 0);
        $display("txn rx drain 0xa0..0xa3");

        // Fill TX to capacity with no credits left
        for (int k = 0; k < 8; k++) begin
            tx_valid_i = 1'b1;
            tx_data_i  = 64'h21 + k;
            @(negedge clk);
        end
        chk("txfull_ready", tx_ready_o, 0);
        chk("txfull_credit", credit_o, 0);
        tx_valid_i = 1'b1; tx_data_i = 64'h99; yummyIn = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0; yummyIn = 1'b0;
        chk("txfull_credit1", credit_o, 1);
        chk("txfull_ready_hold", tx_ready_o, 0);
        @(negedge clk);
        chk("txfull_send_data", dataOut, 64'h25);
        chk("txfull_send_valid", validOut, 1);
        chk("txfull_ready_again", tx_ready_o, 1);
        yummyIn = 1'b1;
        @(negedge clk);
        yummyIn = 1'b0;
        chk("prerst_credit", credit_o, 1);
        chk("prerst_valid", validOut, 0);
        $display("txn tx full, 3 buffered, credit=%0d", credit_o);

        // Asynchronous reset mid-cycle
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", validOut, 0);
        chk("rst_credit", credit_o, 4);
        chk("rst_tx_ready", tx_ready_o, 1);
        chk("rst_err", err_o, 0);
        chk("rst_dataOut", dataOut, 0);
        chk("rst_yummy", yummyOut, 0);
        chk("rst_rx_valid", rx_valid_o, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_valid_%0d", k), validOut, 0);
            chk($sformatf("post_rst_credit_%0d", k), credit_o, 4);
        end
        $display("txn async reset discarded buffered flits");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
